alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Multi-cycle unsigned multiply/divide sequencer that drives one dedicated ALU instance, one ALU operation per clock. MUL uses shift-and-add with ALU add; DIVU/REMU use restoring division with ALU sltu and sub. It sits beside the execute stage. The parent instantiates the ALU and wires it exclusively to this block. Requests and responses use valid/ready handshakes.

## Interface
- WIDTH, 64, operand/result width; must match the ALU width
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset; one clock; reset is synchronous and active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request (high only in IDLE)
- req_op_i  in  2  00 MUL (low WIDTH bits of product), 01 DIVU (quotient), 10 REMU (remainder), 11 reserved
- req_a_i  in  WIDTH  multiplicand / dividend
- req_b_i  in  WIDTH  multiplier / divisor
- resp_valid_o  out  1  result valid, held until accepted
- resp_ready_i  in  1  consumer accepts result
- resp_data_o  out  WIDTH  result, stable while resp_valid_o=1
- busy_o  out  1  high in every state except IDLE
- alu_op1_o  out  WIDTH  ALU operand 1
- alu_op2_o  out  WIDTH  ALU operand 2
- alu_ope_o  out  4  ALU opcode: ADD 4'b0000, SUB 4'b0001, SLTU 4'b0100
- alu_res_i  in  WIDTH  ALU result
- alu_b_flag_i  in  1  ALU flag; under SLTU, 1 means op1<op2

## Operation
- States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE.
- Registers: acc, mcand, mplier, rem, quo, divisor, ge, cnt (log2(WIDTH)+1 bits), result.
- IDLE: req_valid_i&req_ready_o latches the operands.
  - MUL: acc=0, mcand=a, mplier=b, cnt=0, go to MUL.
  - DIVU/REMU with b≠0: rem=0, quo=a, divisor=b, cnt=0, go to DIV_CMP.
  - DIVU with b=0: result=all ones, go to DONE.
  - REMU with b=0: result=a, go to DONE.
  - Reserved op: result=0, go to DONE.
- MUL state:
  - ALU drive: op1=acc, op2=(mplier[0]?mcand:0), ope=ADD.
  - Update: acc<=alu_res_i, mcand<<=1, mplier>>=1, cnt++.
  - After WIDTH iterations: result=acc, go to DONE.
  - Product is taken modulo 2^WIDTH.
- DIV_CMP:
  - Partial value p={rem[WIDTH-2:0],quo[WIDTH-1]}.
  - ALU drive: op1=p, op2=divisor, ope=SLTU.
  - Update: rem<=p, quo<=quo<<1, ge<=rem[WIDTH-1] | ~alu_b_flag_i.
  - rem[WIDTH-1] (the carry-out of the shift) forces ge=1.
  - Go to DIV_SUB.
- DIV_SUB:
  - ALU drive: op1=rem, op2=divisor, ope=SUB.
  - If ge: rem<=alu_res_i (wraps modulo 2^WIDTH) and quo[0]<=1.
  - cnt++.
  - After WIDTH iterations: result=(DIVU?quo:rem), go to DONE. Otherwise go to DIV_CMP.
- DONE:
  - resp_valid_o=1, resp_data_o=result.
  - On resp_ready_i, go to IDLE.
- ALU outputs in IDLE and DONE: op1=0, op2=0, ope=ADD.
- No request overlap: the next request can be accepted only after the response is taken.

## Timing
- Reset values: resp_valid_o=0, resp_data_o=0, busy_o=0, alu_*_o=0; state=IDLE, so req_ready_o=1 after reset.
- Accept edge is cycle 0. resp_valid_o rises at:
  - MUL: cycle WIDTH+1.
  - DIVU/REMU: cycle 2·WIDTH+1.
  - Divide-by-zero or reserved op: cycle 1.
- ALU path is combinational within each cycle; no ALU result is registered outside this block.
- Response accept edge returns to IDLE; req_ready_o=1 on the next cycle.
- Minimum spacing is therefore 2 cycles plus the op latency.
- Backpressure: resp_data_o and resp_valid_o hold indefinitely while resp_ready_i=0.
- req_valid_i outside IDLE is ignored; it is not queued.
- Reset in any state: the next edge enters IDLE with all reset values and discards the in-flight result. No response is issued.

## Structure
- Shared package/header holds:
  - ALU opcode constants (ADD, SUB, SLTU and the rest of the ALU opcode set).
  - MUL/DIVU/REMU op encodings.
  - State encoding.
- No sub-module inside this block; the parent owns the single ALU instance.
- Datapath registers plus one FSM, single always block per concern.

## Test plan
- MUL 7×6 → resp_data_o=42, resp_valid_o rises 65 cycles after accept (WIDTH=64).
- MUL 0xFFFF_FFFF_FFFF_FFFF×2 → 0xFFFF_FFFF_FFFF_FFFE (truncation); alu_ope_o=ADD throughout MUL.
- DIVU 100/7 → 14, REMU 100/7 → 2, each after 129 cycles. Also DIVU 0xFFFF_FFFF_FFFF_FFFF/0x8000_0000_0000_0001 → 1, REMU → 0x7FFF_FFFF_FFFF_FFFE (carry path).
- DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF, REMU 5/0 → 5, reserved op → 0; all at cycle 1.
- Hold resp_ready_i=0 for 5 cycles after resp_valid_o → data stable and req_ready_o=0. A req_valid_i pulse during busy is ignored.
- rst_n_i=0 at cycle 30 of a MUL → IDLE next edge, resp_valid_o never rises, req_ready_o=1. A fresh MUL 3×3 then returns 9.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - opcode set of the external ALU that the sequencer drives
//   - request op encodings (MUL / DIVU / REMU / reserved)
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package alu_muldiv_seq_pkg;

   // External ALU opcode set; the sequencer itself only issues ADD, SUB, SLTU.
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REMU = 2'b10,
      OP_RSVD = 2'b11
   } md_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MUL     = 3'd1,
      ST_DIV_CMP = 3'd2,
      ST_DIV_SUB = 3'd3,
      ST_DONE    = 3'd4
   } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
// Multi-cycle unsigned multiply / divide sequencer. It owns no adder of its
// own: every arithmetic step is one operation on an external ALU, one per
// clock. MUL is shift-and-add (ALU ADD); DIVU/REMU are restoring division
// (ALU SLTU compare, then ALU SUB).
//
// Ports:
//   clk_i, rst_n_i           clock, synchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_op_i                 00 MUL, 01 DIVU, 10 REMU, 11 reserved
//   req_a_i, req_b_i         multiplicand/dividend, multiplier/divisor
//   resp_valid_o/resp_ready_i response handshake, data held until taken
//   resp_data_o              result
//   busy_o                   high whenever not IDLE
//   alu_op1_o/op2_o/ope_o    ALU operands and opcode (combinational)
//   alu_res_i, alu_b_flag_i  ALU result and SLTU "op1<op2" flag
// -----------------------------------------------------------------------------
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_op_i,
   input  logic [WIDTH-1:0] req_a_i,
   input  logic [WIDTH-1:0] req_b_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [WIDTH-1:0] resp_data_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] alu_op1_o,
   output logic [WIDTH-1:0] alu_op2_o,
   output logic [3:0]       alu_ope_o,
   input  logic [WIDTH-1:0] alu_res_i,
   input  logic             alu_b_flag_i
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   md_state_e        state;
   md_op_e           op;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] result;

   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [WIDTH-1:0] rem, quo, divisor;
   logic             ge;

   logic [WIDTH-1:0] div_p;
   logic [WIDTH-1:0] rem_sub, quo_sub;

   // Shift the next dividend bit into the partial remainder.
   assign div_p   = {rem[WIDTH-2:0], quo[WIDTH-1]};
   // Restoring step outcome; used both for the register update and for the
   // final result so the last iteration needs no extra cycle.
   assign rem_sub = ge ? alu_res_i : rem;
   assign quo_sub = ge ? {quo[WIDTH-1:1], 1'b1} : quo;

   assign req_ready_o  = (state == ST_IDLE);
   assign busy_o       = (state != ST_IDLE);
   assign resp_valid_o = (state == ST_DONE);
   assign resp_data_o  = result;

   // ALU drive is a pure function of the current state so its result can be
   // consumed at the same clock edge.
   always_comb begin
      alu_op1_o = '0;
      alu_op2_o = '0;
      alu_ope_o = ALU_ADD;
      case (state)
         ST_MUL: begin
            alu_op1_o = acc;
            alu_op2_o = mplier[0] ? mcand : '0;
            alu_ope_o = ALU_ADD;
         end
         ST_DIV_CMP: begin
            alu_op1_o = div_p;
            alu_op2_o = divisor;
            alu_ope_o = ALU_SLTU;
         end
         ST_DIV_SUB: begin
            alu_op1_o = rem;
            alu_op2_o = divisor;
            alu_ope_o = ALU_SUB;
         end
         default: ;
      endcase
   end

   // Control: FSM, iteration counter, latched op and visible result.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state  <= ST_IDLE;
         op     <= OP_MUL;
         cnt    <= '0;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  op  <= md_op_e'(req_op_i);
                  cnt <= '0;
                  case (md_op_e'(req_op_i))
                     OP_MUL: state <= ST_MUL;
                     OP_DIVU: begin
                        if (req_b_i == '0) begin
                           result <= '1;
                           state  <= ST_DONE;
                        end else begin
                           state  <= ST_DIV_CMP;
                        end
                     end
                     OP_REMU: begin
                        if (req_b_i == '0) begin
                           result <= req_a_i;
                           state  <= ST_DONE;
                        end else begin
                           state  <= ST_DIV_CMP;
                        end
                     end
                     default: begin
                        result <= '0;
                        state  <= ST_DONE;
                     end
                  endcase
               end
            end
            ST_MUL: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  result <= alu_res_i;
                  state  <= ST_DONE;
               end
            end
            ST_DIV_CMP: state <= ST_DIV_SUB;
            ST_DIV_SUB: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  result <= (op == OP_DIVU) ? quo_sub : rem_sub;
                  state  <= ST_DONE;
               end else begin
                  state  <= ST_DIV_CMP;
               end
            end
            ST_DONE: if (resp_ready_i) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath registers; their contents are meaningless until loaded in IDLE.
   always_ff @(posedge clk_i) begin
      case (state)
         ST_IDLE: begin
            if (req_valid_i) begin
               acc     <= '0;
               mcand   <= req_a_i;
               mplier  <= req_b_i;
               rem     <= '0;
               quo     <= req_a_i;
               divisor <= req_b_i;
            end
         end
         ST_MUL: begin
            acc    <= alu_res_i;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
         end
         ST_DIV_CMP: begin
            rem <= div_p;
            quo <= quo << 1;
            // A bit shifted out of rem means p >= 2^WIDTH > divisor.
            ge  <= rem[WIDTH-1] | ~alu_b_flag_i;
         end
         ST_DIV_SUB: begin
            rem <= rem_sub;
            quo <= quo_sub;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_seq
// Self-checking bench for alu_muldiv_seq (WIDTH=64). Provides the external
// ALU behaviourally and compares results/latencies against plain-arithmetic
// reference functions.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_seq;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [W-1:0]  req_a, req_b;
   logic          resp_valid;
   logic          resp_ready;
   logic [W-1:0]  resp_data;
   logic          busy;
   logic [W-1:0]  alu_op1, alu_op2, alu_res;
   logic [3:0]    alu_ope;
   logic          alu_b_flag;

   int n_chk  = 0;
   int n_pass = 0;
   int bad_ope;

   always #5 clk = ~clk;

   alu_muldiv_seq #(.WIDTH(W)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_op_i     (req_op),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_data_o  (resp_data),
      .busy_o       (busy),
      .alu_op1_o    (alu_op1),
      .alu_op2_o    (alu_op2),
      .alu_ope_o    (alu_ope),
      .alu_res_i    (alu_res),
      .alu_b_flag_i (alu_b_flag)
   );

   // External ALU: ADD, SUB, SLTU.
   always_comb begin
      alu_res    = '0;
      alu_b_flag = 1'b0;
      case (alu_ope)
         4'b0000: alu_res = alu_op1 + alu_op2;
         4'b0001: alu_res = alu_op1 - alu_op2;
         4'b0100: begin
            alu_b_flag = (alu_op1 < alu_op2);
            alu_res    = {{(W-1){1'b0}}, alu_b_flag};
         end
         default: ;
      endcase
   end

   function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         2'b00:   return a * b;
         2'b01:   return (b == '0) ? {W{1'b1}} : a / b;
         2'b10:   return (b == '0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] b);
      if (op == 2'b00) return W + 1;
      if ((op == 2'b01 || op == 2'b10) && b != '0) return 2 * W + 1;
      return 1;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // One complete transaction: request, wait for response, optional
   // backpressure, optional ignored request pulse while busy, then accept.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold, input int pulse_at);
      int edges;
      int lat;
      logic [W-1:0] exp;
      exp     = ref_res(op, a, b);
      bad_ope = 0;
      @(posedge clk); #1;
      edges = 0;
      while (!req_ready && edges < 10) begin
         @(posedge clk); #1;
         edges++;
      end
      chk({tag, "_req_ready"}, W'(req_ready), W'(1));
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a     = $urandom;
      req_b     = $urandom;
      edges = 0;
      while (!resp_valid && edges < 300) begin
         if (op == 2'b00 && alu_ope !== 4'b0000) bad_ope++;
         if (edges == pulse_at) begin
            chk({tag, "_busy"}, W'(busy), W'(1));
            req_valid = 1'b1;
            req_op    = 2'b01;
            req_a     = 64'd1234;
            req_b     = 64'd1;
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk); #1;
         edges++;
      end
      req_valid = 1'b0;
      lat = edges + 1;
      chk({tag, "_latency"}, W'(lat), W'(ref_lat(op, b)));
      chk({tag, "_data"}, resp_data, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_data"}, resp_data, exp);
         chk({tag, "_hold_valid"}, W'(resp_valid), W'(1));
         chk({tag, "_hold_ready"}, W'(req_ready), W'(0));
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, "_idle_ready"}, W'(req_ready), W'(1));
      chk({tag, "_idle_valid"}, W'(resp_valid), W'(0));
   endtask

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      int           seen;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp_valid", W'(resp_valid), W'(0));
      chk("rst_resp_data", resp_data, '0);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_req_ready", W'(req_ready), W'(1));
      chk("rst_alu_op1", alu_op1, '0);
      chk("rst_alu_op2", alu_op2, '0);
      chk("rst_alu_ope", W'(alu_ope), W'(0));
      rst_n = 1'b1;

      do_op("mul_7x6", 2'b00, 64'd7, 64'd6, 0, -1);
      do_op("mul_trunc", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, -1);
      chk("mul_ope_add", W'(bad_ope), W'(0));
      do_op("divu_100_7", 2'b01, 64'd100, 64'd7, 0, -1);
      do_op("remu_100_7", 2'b10, 64'd100, 64'd7, 0, -1);
      do_op("divu_carry", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 0, -1);
      do_op("remu_carry", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 0, -1);
      do_op("divu_zero", 2'b01, 64'd5, 64'd0, 0, -1);
      do_op("remu_zero", 2'b10, 64'd5, 64'd0, 0, -1);
      do_op("rsvd", 2'b11, 64'd9, 64'd3, 0, -1);
      do_op("backpressure", 2'b00, 64'd11, 64'd13, 5, 10);

      // Reset in the middle of a MUL discards the operation.
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_a     = 64'd123456789;
      req_b     = 64'd987654321;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst_req_ready", W'(req_ready), W'(1));
      chk("midrst_busy", W'(busy), W'(0));
      chk("midrst_resp_valid", W'(resp_valid), W'(0));
      chk("midrst_resp_data", resp_data, '0);
      seen = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      chk("midrst_no_resp", W'(seen), W'(0));
      do_op("mul_3x3", 2'b00, 64'd3, 64'd3, 0, -1);

      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = 64'($urandom_range(1, 1000));
            2:       b = {$urandom, $urandom};
            default: b = {1'b1, 31'($urandom), $urandom};
         endcase
         if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 5000));
         do_op("rand", op, a, b, int'($urandom_range(0, 2)), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
